// File: rtl/demux_stream_1ton_if.sv
// Stream bundle for the 1-to-N demultiplexer:
// one valid/ready producer side, NCH registered consumer channels.
interface demux_stream_1ton_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
);
   localparam int NCH = 1 << SEL_W;

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [SEL_W-1:0]     in_sel;
   logic                 in_bcast;
   logic                 in_inv;
   logic [NCH-1:0]       out_valid;
   logic [NCH-1:0]       out_ready;
   logic [NCH*WIDTH-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output in_sel,
      output in_bcast,
      output in_inv,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_sel,
      input  in_bcast,
      input  in_inv,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/demux_stream_1ton.sv
// 1-to-N stream demultiplexer with broadcast, optional invert,
// per-channel holding registers and a saturating accept counter.
module demux_stream_1ton #(
   parameter int WIDTH     = 8,
   parameter int SEL_W     = 2,
   parameter int INVERT_EN = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   demux_stream_1ton_if.slave bus,
   output logic [CNT_W-1:0]  xfer_cnt
);
   localparam int NCH = 1 << SEL_W;

   logic [NCH-1:0]            full;
   logic [NCH-1:0][WIDTH-1:0] hold;
   logic [NCH-1:0]            free;
   logic [NCH-1:0]            tgt;
   logic [NCH-1:0]            load;
   logic                      acc;
   logic [WIDTH-1:0]          word;

   // Target set, readiness and the word to be stored.
   always_comb begin
      free = ~full | bus.out_ready;
      tgt  = '0;
      unique case (1'b1)
         bus.in_bcast: tgt = '1;
         default:      tgt[bus.in_sel] = 1'b1;
      endcase
      // Broadcast waits until every channel is free: all-or-nothing.
      bus.in_ready = rst_n & (&(free | ~tgt));
      acc  = bus.in_valid & bus.in_ready;
      load = acc ? tgt : '0;
      word = ((INVERT_EN != 0) && bus.in_inv) ? ~bus.in_data : bus.in_data;
   end

   assign bus.out_valid = full;
   assign bus.out_data  = hold;

   // Per-channel load / drain; a drained channel reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= '0;
         hold <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (load[k]) begin
               hold[k] <= word;
               full[k] <= 1'b1;
            end else if (full[k] && bus.out_ready[k]) begin
               hold[k] <= '0;
               full[k] <= 1'b0;
            end
         end
      end
   end

   // Saturating count of accepted input words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (acc && (xfer_cnt != {CNT_W{1'b1}})) begin
         xfer_cnt <= xfer_cnt + 1'b1;
      end
   end
endmodule

// File: doc/demux_stream_1ton.md
Name: demux_stream_1toN

Overview:
- Parametrised successor to the single-bit 1x2 demultiplexer primitive.
- Routes a WIDTH-bit data word from one valid/ready input stream to one of 2**SEL_W registered output channels, or to all channels at once.
- Has an optional per-word bitwise invert mode, so the same block also provides the demux-as-inverter function.
- Sits between a single producer and several consumers in datapath test designs.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- SEL_W, 2, channel-select width; NCH = 2**SEL_W output channels.
- INVERT_EN, 1, 1 = in_inv honoured; 0 = in_inv ignored and data always passed uninverted.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  data word.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver the word to every channel; in_sel is ignored.
- in_inv  input  1  1 = deliver ~in_data (only when INVERT_EN=1).
- out_valid  output  NCH  per-channel valid.
- out_ready  input  NCH  per-channel ready.
- out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- xfer_cnt  output  CNT_W  number of input words accepted, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, xfer_cnt = 0.
  - in_ready reads 0 while rst_n is low.
  - Held words are discarded. There is no recovery of data caught mid-transfer.
- Channel holding register: one WIDTH-bit register plus a full flag per channel. out_valid[k] = full[k].
- Free condition: channel k is free in a cycle if !full[k] || out_ready[k] (pass-through ready).
- Target set:
  - in_bcast = 1: all channels.
  - in_bcast = 0: only channel in_sel.
- in_ready is combinational and equals AND of free[k] over the target set. It may depend on in_valid-independent inputs only: in_sel, in_bcast, out_ready, full. It must not depend on in_valid.
- Accept when in_valid && in_ready. On accept, at the next rising edge:
  - each target channel loads D = (INVERT_EN && in_inv) ? ~in_data : in_data, and sets full;
  - non-target channels are unaffected;
  - xfer_cnt increments by 1, holding at 2**CNT_W-1.
- Broadcast is all-or-nothing. Either all channels load in the same cycle or none do. There is no partial delivery.
- Drain: if out_valid[k] && out_ready[k] and the channel is not reloaded in that cycle, then full[k] clears and out_data for channel k clears to 0. An idle channel always reads zero, matching the primitive demux, whose unselected output is 0.
- Simultaneous drain and reload on the same channel: the new word is loaded, full stays 1, no bubble.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 word per cycle per channel while that channel's out_ready is held high.
- Output stability: while out_valid[k] && !out_ready[k], out_data for channel k is stable.
- Other channels drain independently of each other.
- in_sel and in_bcast are sampled only in the accept cycle.
- in_valid low: no register changes except drains.
- No combinational path from in_data to out_data (registered outputs).

Test Plan:
- Reset mid-stream: ch2 holds 0xA5, assert rst_n=0 asynchronously between edges → out_valid=0000, out_data=0 and xfer_cnt=0 immediately, before the next edge.
- Unicast and invert: in_data=0x3C, in_sel=1, in_inv=0, all out_ready=1 → next cycle out_valid=0010 and ch1=0x3C. Then in_inv=1 with in_data=0x3C → ch1=0xC3. With INVERT_EN=0 → ch1=0x3C.
- Backpressure: ch0 out_ready=0, send two words to ch0 →
  - first word accepted, in_ready=0 for the second;
  - second word accepted in the same cycle out_ready[0] rises;
  - ch0 shows word1, then word2 with no bubble;
  - xfer_cnt=2.
- Broadcast blocking: ch3 full with out_ready[3]=0, in_bcast=1, in_data=0x55 → in_ready=0 and no channel loads. Raise out_ready[3] → all four channels show 0x55 one cycle later.
- Independent drain: after broadcast 0x55, drop out_ready on ch0/ch2 only → ch1/ch3 clear to valid=0 with data 0; ch0/ch2 hold 0x55 until their ready rises.
- Counter saturation: CNT_W=4, stream 20 words at full rate to rotating channels → xfer_cnt stops at 15 and all 20 words are delivered in order per channel.
